// File: rtl/rx_iq_intf_mc_if.sv
// Sample bus between the receive front-end, the shared I/Q FIFO and the OFDM receiver.
// Valid-only: no ready exists; a word transfers on every rising edge where its valid is high.
interface rx_iq_intf_mc_if #(
  parameter int W = 64
);
  logic [W-1:0] iq_in;
  logic         iq_in_valid;
  logic [W-1:0] iq_out;
  logic         iq_out_valid;

  modport master (
    output iq_in,
    output iq_in_valid,
    input  iq_out,
    input  iq_out_valid
  );

  modport slave (
    input  iq_in,
    input  iq_in_valid,
    output iq_out,
    output iq_out_valid
  );
endinterface

// File: rtl/rx_iq_intf_mc.sv
// Multi-channel I/Q receive FIFO with watermark-paced, run-time-programmable read-out rate.
// Define RX_IQ_STATS_EN to build the saturating overflow/underflow counters.
module rx_iq_intf_mc #(
  parameter int IQ_DATA_WIDTH   = 16,
  parameter int NUM_CH          = 2,
  parameter int FIFO_DEPTH_LOG2 = 5,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  rx_iq_intf_mc_if.slave             bus,
  input  logic                       fifo_in_en,
  input  logic                       fifo_out_en,
  input  logic                       bypass_rate,
  input  logic [CNT_WIDTH-1:0]       clk_per_sample_m1,
  input  logic                       frac_mode,
  input  logic [FIFO_DEPTH_LOG2:0]   low_wm,
  input  logic [FIFO_DEPTH_LOG2:0]   high_wm,
  input  logic                       valid_delay_sel,
  input  logic                       cnt_clr,
  output logic                       fifo_emptyn,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]                ovf_cnt,
  output logic [15:0]                udf_cnt
);
  localparam int W     = NUM_CH * 2 * IQ_DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = FIFO_DEPTH_LOG2;

  logic [W-1:0]         mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level, level_nxt;
  logic                 emptyn_q;
  logic                 empty, full;
  logic                 wren, rden, wr_ok;
  logic                 ovf_ev, udf_ev;

  logic [CNT_WIDTH-1:0] cnt, top, top_calc, period_top;
  logic [CNT_WIDTH-1:0] n_inc, n_dec;
  logic                 phase, tick;

  logic [W-1:0]         d1, d2;
  logic                 v1, v2;

  assign empty  = (level == '0);
  assign full   = (level == LW'(DEPTH));
  assign tick   = (cnt == '0);
  assign wren   = bus.iq_in_valid & fifo_in_en;
  assign rden   = (tick | bypass_rate) & ~empty & fifo_out_en;
  // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
  assign wr_ok  = wren & (~full | rden);
  assign ovf_ev = wren & ~wr_ok;
  assign udf_ev = tick & fifo_out_en & empty & ~bypass_rate;

  always_comb begin
    level_nxt = level;
    case ({wr_ok, rden})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_ok) mem[wr_ptr] <= bus.iq_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      emptyn_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rden)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_nxt;
      emptyn_q <= (level_nxt != '0);
    end
  end

  assign fifo_level  = level;
  assign fifo_emptyn = emptyn_q;

  // Period selection: fill below low_wm slows reads, above high_wm speeds them up.
  always_comb begin
    n_inc    = (clk_per_sample_m1 == '1) ? clk_per_sample_m1 : clk_per_sample_m1 + CNT_WIDTH'(1);
    n_dec    = (clk_per_sample_m1 == '0) ? '0 : clk_per_sample_m1 - CNT_WIDTH'(1);
    top_calc = clk_per_sample_m1;
    if (level < low_wm)       top_calc = n_inc;
    else if (level < high_wm) top_calc = (frac_mode && phase) ? n_inc : clk_per_sample_m1;
    else                      top_calc = frac_mode ? clk_per_sample_m1 : n_dec;
  end

  // Each tick chooses the length of the period it starts, so the wrap compare uses the fresh top.
  assign period_top = tick ? top_calc : top;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      top   <= clk_per_sample_m1;
      phase <= 1'b0;
    end else begin
      cnt <= (cnt >= period_top) ? '0 : cnt + CNT_WIDTH'(1);
      if (tick) begin
        top   <= top_calc;
        phase <= ~phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      d1 <= '0;
      v1 <= 1'b0;
      d2 <= '0;
      v2 <= 1'b0;
    end else begin
      v1 <= rden;
      if (rden) d1 <= mem[rd_ptr];
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  end

  assign bus.iq_out       = valid_delay_sel ? d2 : d1;
  assign bus.iq_out_valid = valid_delay_sel ? v2 : v1;

`ifdef RX_IQ_STATS_EN
  logic [15:0] ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= '0;
      udf_q <= '0;
    end else begin
      if (cnt_clr)                         ovf_q <= '0;
      else if (ovf_ev && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      if (cnt_clr)                         udf_q <= '0;
      else if (udf_ev && udf_q != 16'hFFFF) udf_q <= udf_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_q;
  assign udf_cnt = udf_q;
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_clr, ovf_ev, udf_ev};
  assign ovf_cnt = '0;
  assign udf_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_iq_intf_mc.sv
// Directed bench for rx_iq_intf_mc: rate pacing, watermarks, overflow/underflow, bypass, reset.
module tb_rx_iq_intf_mc;
  localparam int IQW = 16;
  localparam int NCH = 2;
  localparam int DL2 = 5;
  localparam int CW  = 8;
  localparam int W   = NCH * 2 * IQW;
  localparam int LW  = DL2 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          fifo_in_en, fifo_out_en, bypass_rate, frac_mode, valid_delay_sel, cnt_clr;
  logic [CW-1:0] clk_per_sample_m1;
  logic [LW-1:0] low_wm, high_wm, fifo_level;
  logic          fifo_emptyn;
  logic [15:0]   ovf_cnt, udf_cnt;

  rx_iq_intf_mc_if #(.W(W)) bus ();

  rx_iq_intf_mc #(
    .IQ_DATA_WIDTH  (IQW),
    .NUM_CH         (NCH),
    .FIFO_DEPTH_LOG2(DL2),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .bus              (bus),
    .fifo_in_en       (fifo_in_en),
    .fifo_out_en      (fifo_out_en),
    .bypass_rate      (bypass_rate),
    .clk_per_sample_m1(clk_per_sample_m1),
    .frac_mode        (frac_mode),
    .low_wm           (low_wm),
    .high_wm          (high_wm),
    .valid_delay_sel  (valid_delay_sel),
    .cnt_clr          (cnt_clr),
    .fifo_emptyn      (fifo_emptyn),
    .fifo_level       (fifo_level),
    .ovf_cnt          (ovf_cnt),
    .udf_cnt          (udf_cnt)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_w;
  int pulse_q[$];
  int pulse_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (rstn && bus.iq_out_valid) begin
      pulse_cnt++;
      pulse_q.push_back(cyc);
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed word %0h, required no word", bus.iq_out);
      end
      if (exp_q.size() > 0) begin
        sb_w = exp_q.pop_front();
        n_cmp++;
        assert (bus.iq_out === sb_w) else begin
          n_err++;
          $error("FAIL sb_data: observed %0h expected %0h", bus.iq_out, sb_w);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    exp_q.delete();
    step(n);
    rstn = 1'b1;
  endtask

  task automatic push_word(input bit accept);
    logic [W-1:0] w;
    w = {$urandom(), $urandom()};
    bus.iq_in = w;
    bus.iq_in_valid = 1'b1;
    if (accept) exp_q.push_back(w);
    step(1);
    bus.iq_in_valid = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (pulse_q.size() < n && k < budget) begin
      step(1);
      k++;
    end
    n_cmp++;
    assert (pulse_q.size() >= n) else begin
      n_err++;
      $error("FAIL wait_pulses: observed %0d pulses required %0d", pulse_q.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cyc, p0, g0, lvl, eg, exp_ovf, exp_udf;
`ifdef RX_IQ_STATS_EN
    exp_ovf = 8;
    exp_udf = 4;
`else
    exp_ovf = 0;
    exp_udf = 0;
`endif
    bus.iq_in = '0;
    bus.iq_in_valid = 1'b0;
    fifo_in_en = 1'b1;
    fifo_out_en = 1'b0;
    bypass_rate = 1'b0;
    frac_mode = 1'b0;
    valid_delay_sel = 1'b0;
    cnt_clr = 1'b0;
    clk_per_sample_m1 = CW'(4);
    low_wm = LW'(11);
    high_wm = LW'(22);

    // reset values
    do_reset(2);
    check("rst_iq_out", bus.iq_out, 0);
    check("rst_valid", bus.iq_out_valid, 0);
    check("rst_emptyn", fifo_emptyn, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_udf", udf_cnt, 0);

    // steady rate, mid band, integer period of 5
    for (int i = 0; i < 15; i++) push_word(1'b1);
    check("steady_level", fifo_level, 15);
    check("steady_emptyn", fifo_emptyn, 1);
    pulse_q.delete();
    fifo_out_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_word(1'b1);
      step(4);
    end
    wait_pulses(10, 60);
    for (int i = 0; i < 9; i++) check("gap_steady", pulse_q[i+1] - pulse_q[i], 5);

    // fractional rate: 5,6,5,6 spacing in mid band
    fifo_out_en = 1'b0;
    frac_mode = 1'b1;
    do_reset(1);
    for (int i = 0; i < 15; i++) push_word(1'b1);
    pulse_q.delete();
    fifo_out_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push_word(1'b1);
      step(4);
    end
    wait_pulses(11, 80);
    g0 = pulse_q[1] - pulse_q[0];
    check("frac_gap0_5_or_6", (g0 == 5 || g0 == 6), 1);
    for (int i = 1; i < 10; i++)
      check("gap_frac", pulse_q[i+1] - pulse_q[i], (i % 2 == 0) ? g0 : 11 - g0);

    // overflow burst then watermark-driven drain
    fifo_out_en = 1'b0;
    frac_mode = 1'b0;
    do_reset(1);
    for (int i = 0; i < 40; i++) push_word(i < 32);
    check("burst_level", fifo_level, 32);
    check("burst_emptyn", fifo_emptyn, 1);
    check("burst_ovf", ovf_cnt, exp_ovf);
    pulse_q.delete();
    fifo_out_en = 1'b1;
    wait_pulses(25, 200);
    for (int k = 1; k <= 24; k++) begin
      lvl = 33 - k;
      eg = (lvl >= 22) ? 4 : (lvl >= 11) ? 5 : 6;
      check("gap_drain", pulse_q[k] - pulse_q[k-1], eg);
    end

    // underflow with no writes, then clear
    fifo_out_en = 1'b0;
    do_reset(1);
    fifo_out_en = 1'b1;
    p0 = pulse_cnt;
    step(20);
    check("udf_count", udf_cnt, exp_udf);
    check("udf_no_valid", pulse_cnt - p0, 0);
    cnt_clr = 1'b1;
    step(1);
    cnt_clr = 1'b0;
    check("udf_cleared", udf_cnt, 0);

    // bypass, one output stage
    fifo_out_en = 1'b0;
    valid_delay_sel = 1'b0;
    do_reset(1);
    for (int i = 0; i < 3; i++) push_word(1'b1);
    step(1);
    pulse_q.delete();
    bypass_rate = 1'b1;
    fifo_out_en = 1'b1;
    en_cyc = cyc;
    wait_pulses(3, 10);
    step(5);
    check("byp0_count", pulse_q.size(), 3);
    for (int i = 0; i < 3; i++) check("byp0_time", pulse_q[i] - en_cyc, i + 1);

    // bypass, two output stages
    fifo_out_en = 1'b0;
    bypass_rate = 1'b0;
    valid_delay_sel = 1'b1;
    do_reset(1);
    for (int i = 0; i < 3; i++) push_word(1'b1);
    step(1);
    pulse_q.delete();
    bypass_rate = 1'b1;
    fifo_out_en = 1'b1;
    en_cyc = cyc;
    wait_pulses(3, 10);
    step(5);
    check("byp1_count", pulse_q.size(), 3);
    for (int i = 0; i < 3; i++) check("byp1_time", pulse_q[i] - en_cyc, i + 2);

    // mid-stream reset with 10 words queued
    fifo_out_en = 1'b0;
    bypass_rate = 1'b0;
    valid_delay_sel = 1'b0;
    do_reset(1);
    for (int i = 0; i < 11; i++) push_word(1'b1);
    bypass_rate = 1'b1;
    fifo_out_en = 1'b1;
    step(1);
    fifo_out_en = 1'b0;
    bypass_rate = 1'b0;
    check("pre_rst_level", fifo_level, 10);
    step(2);
    fifo_out_en = 1'b1;
    bypass_rate = 1'b1;
    do_reset(1);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_emptyn", fifo_emptyn, 0);
    check("mid_rst_iq_out", bus.iq_out, 0);
    check("mid_rst_valid", bus.iq_out_valid, 0);
    p0 = pulse_cnt;
    step(12);
    check("mid_rst_no_pulses", pulse_cnt - p0, 0);
    check("mid_rst_level_after", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
